ysyx_23060077_riscv_idu_pipe: RTL and testbench
===============================================

YSYX_23060077_RISCV_IDU_PIPE -- requirements
Module: ysyx_23060077_riscv_idu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64) for pc and imm.
REQ-002 SHALL have parameter ALU_OPT_WIDTH, default 4, alu_opt width.
REQ-003 SHALL have parameter LSU_OPT_WIDTH, default 5, lsu_opt width.
REQ-004 SHALL have parameter SRC_SEL_WIDTH, default 2, src_sel width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  discard all held and incoming instructions.
REQ-008 in_valid  input  1  upstream instruction valid.
REQ-009 in_ready  output  1  block can accept an instruction.
REQ-010 in_inst  input  32  instruction word.
REQ-011 in_pc  input  XLEN  instruction address.
REQ-012 out_valid  output  1  decoded bundle valid.
REQ-013 out_ready  input  1  downstream accepts bundle.
REQ-014 alu_opt  output  ALU_OPT_WIDTH  ADD=0,SUB=1,SLL=2,SLT=3,SLTU=4,XOR=5,SRL=6,SRA=7,OR=8,AND=9.
REQ-015 src_sel  output  SRC_SEL_WIDTH  bit1: src1 0=rs1/1=pc; bit0: src2 0=rs2/1=imm.
REQ-016 lsu_opt  output  LSU_OPT_WIDTH  {mem_en, is_store, funct3}; 0 for non-memory.
REQ-017 imm  output  XLEN  sign-extended immediate (I/S/B/U/J by opcode), 0 for R-type.
REQ-018 rs1, rs2, rd  output  5 each  register indices from inst[19:15], [24:20], [11:7].
REQ-019 rd_wen  output  1  destination write enable.
REQ-020 illegal  output  1  opcode/funct3/funct7 combination outside RV32I base.
REQ-021 out_pc  output  XLEN  pc of the presented bundle.

Function
REQ-022 Decode key SHALL be {opcode, funct3}, plus funct7[5] for OP and shift OP_IMM (SUB, SRA, SRAI).
REQ-023 LUI SHALL give alu ADD, src1 forced rs1 with rs1 index output 0, src2 imm; AUIPC alu ADD, src_sel=2'b11.
REQ-024 JAL/JALR SHALL give alu ADD, src_sel=2'b11 (link = pc+4 computed downstream via imm? no: imm carries offset), rd_wen=1; BRANCH rd_wen=0, alu SUB/SLT/SLTU per funct3.
REQ-025 LOAD SHALL give lsu_opt={1,0,funct3}, STORE {1,1,funct3}, rd_wen=0 for STORE/BRANCH, src_sel=2'b01 for both.
REQ-026 FENCE and SYS SHALL decode legal with alu ADD, lsu 0, rd_wen=0 (FENCE) or funct3!=0 (SYS).
REQ-027 Illegal instructions SHALL assert illegal=1 with alu ADD, lsu 0, rd_wen=0, and still flow through the handshake.
REQ-028 imm SHALL be sign-extended from inst[31] to XLEN bits; U-type imm = {inst[31:12],12'b0} sign-extended.
REQ-029 Transfer in SHALL occur when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-030 Outputs SHALL be registered; an accepted instruction SHALL appear at out_valid the next cycle (latency 1) when the output stage is empty or draining.
REQ-031 Block SHALL hold a 2-entry buffer: output register plus one skid register; states EMPTY, ONE, TWO.
REQ-032 EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE stays on accept+drain; TWO->ONE on drain (skid moves to output register).
REQ-033 in_ready SHALL be registered, equal to (state!=TWO), never combinationally dependent on out_ready.
REQ-034 Order SHALL be preserved; no bundle lost or duplicated under any valid/ready pattern.
REQ-035 Outputs SHALL remain stable while out_valid&&!out_ready.
REQ-036 flush SHALL take priority: next state EMPTY, out_valid=0, in_ready=1; instruction presented in the flush cycle is dropped.

Reset
REQ-037 On rst_n low SHALL immediately set state EMPTY, out_valid=0, in_ready=1, all other outputs 0, regardless of in-flight data.
REQ-038 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-039 addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, alu 0, src_sel 2'b01, imm 0xFFFFFFFF (XLEN=32) / 0xFFFF_FFFF_FFFF_FFFF (XLEN=64), rs1=2, rd=1, rd_wen=1.
REQ-040 sw x5,8(x2) (0x00512423) -> lsu_opt 5'b11010, imm 8, rs1=2, rs2=5, rd_wen=0, illegal=0.
REQ-041 out_ready=0 for 3 cycles, in_valid=1 with three distinct words -> two accepted, in_ready=0 after second, third held upstream; releasing out_ready yields all three in order.
REQ-042 State TWO, flush=1 one cycle -> next cycle out_valid=0, in_ready=1; no flushed pc ever appears at out_pc.
REQ-043 0x00000000 and funct7=0x01 on OP -> illegal=1, lsu 0, rd_wen=0, handshake completes normally.
REQ-044 rst_n pulled low mid-stream in state TWO -> out_valid=0 and in_ready=1 without waiting for clk.

Source files
------------

// File: rtl/ysyx_23060077_riscv_idu_pipe.sv
// RV32I decode stage with a 2-entry elastic buffer (output register + skid register).
// Decoded bundles leave in order with one cycle of latency; in_ready is a pure register.
module ysyx_23060077_riscv_idu_pipe #(
  parameter int XLEN          = 32,
  parameter int ALU_OPT_WIDTH = 4,
  parameter int LSU_OPT_WIDTH = 5,
  parameter int SRC_SEL_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_OPT_WIDTH-1:0] alu_opt,
  output logic [SRC_SEL_WIDTH-1:0] src_sel,
  output logic [LSU_OPT_WIDTH-1:0] lsu_opt,
  output logic [XLEN-1:0]          imm,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     rd_wen,
  output logic                     illegal,
  output logic [XLEN-1:0]          out_pc,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;

  typedef struct packed {
    logic [ALU_OPT_WIDTH-1:0] alu;
    logic [SRC_SEL_WIDTH-1:0] src;
    logic [LSU_OPT_WIDTH-1:0] lsu;
    logic [XLEN-1:0]          imm;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic                     wen;
    logic                     ill;
    logic [XLEN-1:0]          pc;
  } bundle_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  localparam logic [ALU_OPT_WIDTH-1:0] ALU_ADD = ALU_OPT_WIDTH'(0), ALU_SUB = ALU_OPT_WIDTH'(1);
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLL = ALU_OPT_WIDTH'(2), ALU_SLT = ALU_OPT_WIDTH'(3);
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLTU = ALU_OPT_WIDTH'(4), ALU_XOR = ALU_OPT_WIDTH'(5);
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SRL = ALU_OPT_WIDTH'(6), ALU_SRA = ALU_OPT_WIDTH'(7);
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OR = ALU_OPT_WIDTH'(8), ALU_AND = ALU_OPT_WIDTH'(9);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm32;
  logic        legal;
  bundle_t     dec;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  always_comb begin
    dec     = '0;
    imm32   = '0;
    legal   = 1'b1;
    dec.alu = ALU_ADD;
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd  = in_inst[11:7];
    dec.pc  = in_pc;
    case (opc)
      OP_LUI:   begin imm32 = {in_inst[31:12], 12'b0}; dec.src = SRC_SEL_WIDTH'(2'b01); dec.rs1 = '0; dec.wen = 1'b1; end
      OP_AUIPC: begin imm32 = {in_inst[31:12], 12'b0}; dec.src = SRC_SEL_WIDTH'(2'b11); dec.wen = 1'b1; end
      OP_JAL: begin
        imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec.src = SRC_SEL_WIDTH'(2'b11);
        dec.wen = 1'b1;
      end
      OP_JALR: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.src = SRC_SEL_WIDTH'(2'b11);
        dec.wen = 1'b1;
        legal   = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        case (f3[2:1])
          2'b00:   dec.alu = ALU_SUB;
          2'b10:   dec.alu = ALU_SLT;
          2'b11:   dec.alu = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.src = SRC_SEL_WIDTH'(2'b01);
        dec.lsu = LSU_OPT_WIDTH'({2'b10, f3});
        dec.wen = 1'b1;
        legal   = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OP_STORE: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec.src = SRC_SEL_WIDTH'(2'b01);
        dec.lsu = LSU_OPT_WIDTH'({2'b11, f3});
        legal   = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
      end
      OP_IMM, OP_OP: begin
        if (opc == OP_IMM) begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec.src = SRC_SEL_WIDTH'(2'b01);
        end
        dec.wen = 1'b1;
        case (f3)
          3'b000:  dec.alu = (opc == OP_OP && f7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu = ALU_SLL;
          3'b010:  dec.alu = ALU_SLT;
          3'b011:  dec.alu = ALU_SLTU;
          3'b100:  dec.alu = ALU_XOR;
          3'b101:  dec.alu = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu = ALU_OR;
          default: dec.alu = ALU_AND;
        endcase
        // funct7 only matters for OP and for the immediate shifts
        if (opc == OP_OP || f3 == 3'b001 || f3 == 3'b101)
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b101 || (f3 == 3'b000 && opc == OP_OP)));
      end
      OP_FENCE: begin imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; legal = (f3 == 3'b000); end
      OP_SYS: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.wen = (f3 != 3'b000);
        legal   = (f3 != 3'b100);
      end
      default: legal = 1'b0;
    endcase
    dec.imm        = {XLEN{imm32[31]}};
    dec.imm[31:0]  = imm32;
    if (!legal) begin
      dec.alu = ALU_ADD;
      dec.src = '0;
      dec.lsu = '0;
      dec.imm = '0;
      dec.wen = 1'b0;
      dec.ill = 1'b1;
    end
  end

  // Handshake: a bundle moves on a side only in a cycle where that side's valid and ready are both high.
  state_e  state_q;
  logic    in_ready_q, out_valid_q, accept, drain;
  bundle_t out_q, skid_q;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
          state_q     <= S_ONE;
        end
        S_ONE: begin
          if (accept && !drain) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state_q    <= S_TWO;
          end else if (accept) begin
            out_q <= dec;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= S_EMPTY;
          end
        end
        S_TWO: if (drain) begin
          out_q      <= skid_q;
          in_ready_q <= 1'b1;
          state_q    <= S_ONE;
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_opt   = out_q.alu;
  assign src_sel   = out_q.src;
  assign lsu_opt   = out_q.lsu;
  assign imm       = out_q.imm;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign rd_wen    = out_q.wen;
  assign illegal   = out_q.ill;
  assign out_pc    = out_q.pc;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_idu_pipe.sv
// Directed bench for the decode stage: decode vectors, backpressure, flush and async reset.
module tb_ysyx_23060077_riscv_idu_pipe;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, imm, out_pc;
  logic [3:0]  alu_opt;
  logic [1:0]  src_sel, dbg_state;
  logic [4:0]  lsu_opt, rs1, rs2, rd;
  logic        rd_wen, illegal;
  int          n_assert, n_fail;

  ysyx_23060077_riscv_idu_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .alu_opt(alu_opt), .src_sel(src_sel), .lsu_opt(lsu_opt), .imm(imm), .rs1(rs1),
    .rs2(rs2), .rd(rd), .rd_wen(rd_wen), .illegal(illegal), .out_pc(out_pc),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic exp_bundle(input string tag, input logic [3:0] e_alu, input logic [1:0] e_src,
                            input logic [4:0] e_lsu, input logic [31:0] e_imm, input logic [4:0] e_rs1,
                            input logic [4:0] e_rs2, input logic [4:0] e_rd, input logic e_wen,
                            input logic e_ill, input logic [31:0] e_pc);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".alu"}, alu_opt, e_alu);
    chk({tag, ".src"}, src_sel, e_src);
    chk({tag, ".lsu"}, lsu_opt, e_lsu);
    chk({tag, ".imm"}, imm, e_imm);
    chk({tag, ".rs1"}, rs1, e_rs1);
    chk({tag, ".rs2"}, rs2, e_rs2);
    chk({tag, ".rd"}, rd, e_rd);
    chk({tag, ".wen"}, rd_wen, e_wen);
    chk({tag, ".ill"}, illegal, e_ill);
    chk({tag, ".pc"}, out_pc, e_pc);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.state", dbg_state, 2'd0);
    chk("rst.imm", imm, 32'h0);
    chk("rst.out_pc", out_pc, 32'h0);

    // decode stream with out_ready held high
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF10093, 32'h100);
    tick();
    exp_bundle("addi", 4'd0, 2'b01, 5'h00, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 32'h100);
    drive(1'b1, 32'h00512423, 32'h104);
    tick();
    exp_bundle("sw", 4'd0, 2'b01, 5'h1A, 32'h8, 5'd2, 5'd5, 5'd8, 1'b0, 1'b0, 32'h104);
    drive(1'b1, 32'h00000000, 32'h108);
    tick();
    exp_bundle("zero", 4'd0, 2'b00, 5'h00, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h108);
    drive(1'b1, 32'h022081B3, 32'h10C);
    tick();
    exp_bundle("mul", 4'd0, 2'b00, 5'h00, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 32'h10C);
    drive(1'b1, 32'h402081B3, 32'h110);
    tick();
    exp_bundle("sub", 4'd1, 2'b00, 5'h00, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h110);
    drive(1'b1, 32'h123452B7, 32'h114);
    tick();
    exp_bundle("lui", 4'd0, 2'b01, 5'h00, 32'h12345000, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 32'h114);
    drive(1'b1, 32'h4030D213, 32'h118);
    tick();
    exp_bundle("srai", 4'd7, 2'b01, 5'h00, 32'h403, 5'd1, 5'd3, 5'd4, 1'b1, 1'b0, 32'h118);
    drive(1'b1, 32'h00208463, 32'h11C);
    tick();
    exp_bundle("beq", 4'd1, 2'b00, 5'h00, 32'h8, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 32'h11C);
    drive(1'b1, 32'h0020E463, 32'h120);
    tick();
    exp_bundle("bltu", 4'd4, 2'b00, 5'h00, 32'h8, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 32'h120);
    drive(1'b1, 32'h010000EF, 32'h124);
    tick();
    exp_bundle("jal", 4'd0, 2'b11, 5'h00, 32'h10, 5'd0, 5'd16, 5'd1, 1'b1, 1'b0, 32'h124);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain.out_valid", out_valid, 1'b0);
    chk("drain.state", dbg_state, 2'd0);

    // backpressure: two accepted, third held upstream
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    tick();
    chk("bp1.in_ready", in_ready, 1'b1);
    chk("bp1.pc", out_pc, 32'h200);
    drive(1'b1, 32'h00200093, 32'h204);
    tick();
    chk("bp2.in_ready", in_ready, 1'b0);
    chk("bp2.state", dbg_state, 2'd2);
    chk("bp2.pc", out_pc, 32'h200);
    drive(1'b1, 32'h00300093, 32'h208);
    tick();
    chk("bp3.in_ready", in_ready, 1'b0);
    chk("bp3.pc", out_pc, 32'h200);
    chk("bp3.imm", imm, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("rel1.pc", out_pc, 32'h204);
    chk("rel1.imm", imm, 32'h2);
    chk("rel1.in_ready", in_ready, 1'b1);
    tick();
    chk("rel2.pc", out_pc, 32'h208);
    chk("rel2.imm", imm, 32'h3);
    chk("rel2.valid", out_valid, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("rel3.out_valid", out_valid, 1'b0);

    // flush from state TWO, with a new word offered in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h300);
    tick();
    drive(1'b1, 32'h00200093, 32'h304);
    tick();
    chk("fl.pre_state", dbg_state, 2'd2);
    drive(1'b1, 32'h00300093, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    chk("fl.out_valid", out_valid, 1'b0);
    chk("fl.in_ready", in_ready, 1'b1);
    tick();
    chk("fl.idle_valid", out_valid, 1'b0);
    drive(1'b1, 32'h00400093, 32'h30C);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("fl.next_pc", out_pc, 32'h30C);
    chk("fl.next_imm", imm, 32'h4);
    tick();
    chk("fl.after_valid", out_valid, 1'b0);

    // asynchronous reset while holding two bundles
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h400);
    tick();
    drive(1'b1, 32'h00600093, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar.pre_state", dbg_state, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", out_valid, 1'b0);
    chk("ar.in_ready", in_ready, 1'b1);
    chk("ar.state", dbg_state, 2'd0);
    chk("ar.out_pc", out_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar.post_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
